// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and protocol-byte helper for the
// PS/2 keyboard receiver.
package ps2_pkg;

  // Scan-code prefixes
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  // Bytes that follow E1 in the Pause make/break sequence
  localparam int unsigned PS2_PAUSE_SKIP = 7;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_frame_state_e;

  // Keyboard replies/ACKs that never represent a key when no prefix is pending
  function automatic logic ps2_is_protocol(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the pins, debounces the clock line,
// assembles 11-bit frames and checks start/parity/stop.
// Ports:
//   clock, reset   system clock, async active-low reset
//   ps2Ck, ps2Dq   raw PS/2 pins (asynchronous)
//   rxStrb         one-cycle pulse, rxByte holds a good byte
//   rxByte[7:0]    last good byte
//   rxErr          one-cycle pulse on a frame with bad parity or stop bit
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 64000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2Dq,
  output logic       rxStrb,
  output logic [7:0] rxByte,
  output logic       rxErr
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]       ck_sync;
  logic [1:0]       dq_sync;
  logic             ck_s;
  logic             dq_s;
  logic [FW-1:0]    flt_cnt;
  logic             ck_f;
  logic             ck_f_d;
  logic             fall_c;
  logic [TW-1:0]    to_cnt;
  logic             to_hit_c;

  ps2_frame_state_e state, state_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             par, par_nx;
  logic             rx_strb_nx;
  logic [7:0]       rx_byte_nx;
  logic             rx_err_nx;

  // 2-FF synchronizers; reset to the idle line level so no false edge follows reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync <= 2'b11;
      dq_sync <= 2'b11;
    end else begin
      ck_sync <= {ck_sync[0], ps2Ck};
      dq_sync <= {dq_sync[0], ps2Dq};
    end
  end

  assign ck_s = ck_sync[1];
  assign dq_s = dq_sync[1];

  // Clock debouncer: FILTER consecutive differing samples flip ck_f, any agreement reloads
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flt_cnt <= '0;
      ck_f    <= 1'b1;
      ck_f_d  <= 1'b1;
    end else begin
      ck_f_d <= ck_f;
      if (ck_s == ck_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER - 1)) begin
        flt_cnt <= '0;
        ck_f    <= ck_s;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // Sample event: first cycle with filtered clock low
  assign fall_c = ck_f_d & ~ck_f;

  // Inactivity timer, cleared by every sample event, saturating
  assign to_hit_c = (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (fall_c) begin
      to_cnt <= '0;
    end else if (!to_hit_c) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Frame FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      rxStrb  <= 1'b0;
      rxByte  <= '0;
      rxErr   <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
      rxStrb  <= rx_strb_nx;
      rxByte  <= rx_byte_nx;
      rxErr   <= rx_err_nx;
    end
  end

  // Frame FSM next state; a sample event takes priority over the timeout
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    rx_strb_nx = 1'b0;
    rx_byte_nx = rxByte;
    rx_err_nx  = 1'b0;
    if (fall_c) begin
      case (state)
        ST_IDLE: begin
          if (!dq_s) begin
            state_nx   = ST_DATA;
            bit_cnt_nx = '0;
          end
        end
        ST_DATA: begin
          shreg_nx = {dq_s, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nx = ST_PARITY;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          par_nx   = dq_s;
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (dq_s && (^{shreg, par})) begin
            rx_strb_nx = 1'b1;
            rx_byte_nx = shreg;
          end else begin
            rx_err_nx = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (to_hit_c && (state != ST_IDLE)) begin
      state_nx = ST_IDLE;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver and set-2 scan-code decoder. Folds E0/F0 prefixes
// into a single key event and swallows the Pause (E1) sequence.
// Ports:
//   clock, reset   system clock, async active-low reset
//   ps2Ck, ps2Dq   raw PS/2 pins (never driven)
//   strb           one-cycle pulse per key event
//   make           1 = press, 0 = release (held)
//   code[7:0]      scan code without prefixes (held)
//   ext            event was E0-prefixed (held)
//   perr           one-cycle pulse on a bad frame
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 64000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2Dq,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       perr
);

  logic       rx_strb;
  logic [7:0] rx_byte;
  logic       rx_err;

  logic       brk, brk_nx;
  logic       extf, extf_nx;
  logic [2:0] skip, skip_nx;
  logic       strb_nx;
  logic       make_nx;
  logic [7:0] code_nx;
  logic       ext_nx;

  ps2_rx_frame #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_frame (
    .clock  (clock),
    .reset  (reset),
    .ps2Ck  (ps2Ck),
    .ps2Dq  (ps2Dq),
    .rxStrb (rx_strb),
    .rxByte (rx_byte),
    .rxErr  (rx_err)
  );

  // rxErr is already a registered one-cycle pulse
  assign perr = rx_err;

  // Decoder state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk  <= 1'b0;
      extf <= 1'b0;
      skip <= '0;
      strb <= 1'b0;
      make <= 1'b0;
      code <= '0;
      ext  <= 1'b0;
    end else begin
      brk  <= brk_nx;
      extf <= extf_nx;
      skip <= skip_nx;
      strb <= strb_nx;
      make <= make_nx;
      code <= code_nx;
      ext  <= ext_nx;
    end
  end

  // Prefix decoder; skip has precedence, a bad frame flushes all pending prefixes
  always_comb begin
    brk_nx  = brk;
    extf_nx = extf;
    skip_nx = skip;
    strb_nx = 1'b0;
    make_nx = make;
    code_nx = code;
    ext_nx  = ext;
    if (rx_err) begin
      brk_nx  = 1'b0;
      extf_nx = 1'b0;
      skip_nx = '0;
    end else if (rx_strb) begin
      if (skip != 3'd0) begin
        skip_nx = skip - 3'd1;
      end else if (rx_byte == PS2_E1) begin
        skip_nx = 3'(PS2_PAUSE_SKIP);
      end else if (rx_byte == PS2_E0) begin
        extf_nx = 1'b1;
      end else if (rx_byte == PS2_F0) begin
        brk_nx = 1'b1;
      end else if (!brk && !extf && ps2_is_protocol(rx_byte)) begin
        strb_nx = 1'b0;
      end else begin
        strb_nx = 1'b1;
        code_nx = rx_byte;
        make_nx = ~brk;
        ext_nx  = extf;
        brk_nx  = 1'b0;
        extf_nx = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed sequences plus random frames, checked
// against a byte-level model of the scan-code rules.
module tb_ps2_keyboard_rx;

  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 400;
  localparam int HALF     = 30;
  localparam int STRB_LAT = 2 + FILTER + 2;
  localparam int PERR_LAT = 2 + FILTER + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Ck = 1'b1;
  logic       ps2Dq = 1'b1;
  logic       strb;
  logic       make;
  logic [7:0] code;
  logic       ext;
  logic       perr;

  int n_checks = 0;
  int n_errors = 0;
  int strb_total = 0;
  int perr_total = 0;
  int strb_b2b = 0;
  logic strb_prev = 1'b0;

  // Reference model state
  bit       m_brk = 0;
  bit       m_extf = 0;
  int       m_skip = 0;
  logic [7:0] exp_code = 8'h00;
  bit       exp_make = 0;
  bit       exp_ext = 0;
  int       exp_events = 0;
  int       exp_perrs = 0;

  always #5 clock = ~clock;

  ps2_keyboard_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ps2Ck (ps2Ck),
    .ps2Dq (ps2Dq),
    .strb  (strb),
    .make  (make),
    .code  (code),
    .ext   (ext),
    .perr  (perr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Global pulse counters
  always @(negedge clock) begin
    if (reset) begin
      if (strb) strb_total++;
      if (perr) perr_total++;
      if (strb && strb_prev) strb_b2b++;
    end
    strb_prev = strb;
  end

  // Byte-level model of the decoder rules
  task automatic model_frame(input logic [7:0] b, input bit good,
                             output bit ev, output logic [7:0] c, output bit mk, output bit ex);
    ev = 0; c = 8'h00; mk = 0; ex = 0;
    if (!good) begin
      m_brk = 0; m_extf = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_extf = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_brk && !m_extf &&
                 (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
      ev = 0;
    end else begin
      ev = 1; c = b; mk = !m_brk; ex = m_extf;
      m_brk = 0; m_extf = 0;
    end
  endtask

  // One PS/2 bit cell; an optional short low glitch during the high phase
  task automatic send_bit(input logic b, input bit glitch);
    ps2Dq = b;
    if (glitch) begin
      repeat (8) @(negedge clock);
      ps2Ck = 1'b0;
      repeat (3) @(negedge clock);
      ps2Ck = 1'b1;
      repeat (HALF - 11) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2Ck = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2Ck = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitchy);
    bit ev, mk, ex;
    logic [7:0] c;
    logic p;
    int t_s, t_p, n_s, n_p;
    bit bad;
    bad = bad_par || bad_stop;
    p = (~^b) ^ bad_par;
    model_frame(b, !bad, ev, c, mk, ex);
    send_bit(1'b0, glitchy && ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 8; i++) send_bit(b[i], glitchy && ($urandom_range(0, 3) == 0));
    send_bit(p, 1'b0);
    ps2Dq = !bad_stop;
    repeat (HALF) @(negedge clock);
    ps2Ck = 1'b0;
    t_s = -1; t_p = -1; n_s = 0; n_p = 0;
    for (int k = 1; k <= HALF + 25; k++) begin
      @(negedge clock);
      if (strb) begin n_s++; if (t_s < 0) t_s = k; end
      if (perr) begin n_p++; if (t_p < 0) t_p = k; end
      if (k == HALF) ps2Ck = 1'b1;
    end
    ps2Dq = 1'b1;
    check($sformatf("strb_count[%02h]", b), n_s, ev ? 1 : 0);
    check($sformatf("perr_count[%02h]", b), n_p, bad ? 1 : 0);
    if (ev) begin
      exp_code = c; exp_make = mk; exp_ext = ex;
      exp_events++;
      check($sformatf("strb_latency[%02h]", b), t_s, STRB_LAT);
    end
    if (bad) begin
      exp_perrs++;
      check($sformatf("perr_latency[%02h]", b), t_p, PERR_LAT);
    end
    check($sformatf("code[%02h]", b), code, exp_code);
    check($sformatf("make[%02h]", b), make, exp_make);
    check($sformatf("ext[%02h]", b), ext, exp_ext);
    repeat (20) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strb"}, strb, 0);
    check({tag, "_make"}, make, 0);
    check({tag, "_code"}, code, 0);
    check({tag, "_ext"},  ext, 0);
    check({tag, "_perr"}, perr, 0);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, p0;
    logic [7:0] rb;
    int pick;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (30) @(negedge clock);

    // Plain make, break, extended break
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);

    // Pause sequence swallowed, then one event
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    send_frame(8'hE1, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);

    // Protocol byte dropped; bad parity flushes a pending F0
    send_frame(8'hFA, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h5A, 0, 1, 0);

    // Spurious falling edge with data high in idle
    s0 = strb_total; p0 = perr_total;
    send_bit(1'b1, 1'b0);
    repeat (40) @(negedge clock);
    check("spurious_strb", strb_total, s0);
    check("spurious_perr", perr_total, p0);

    // Partial frame abandoned by timeout
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    repeat (TIMEOUT + 100) @(negedge clock);
    check("timeout_strb", strb_total, s0);
    check("timeout_perr", perr_total, p0);
    send_frame(8'h29, 0, 0, 0);

    // Reset mid-frame with an F0 pending
    send_frame(8'hF0, 0, 0, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("midreset");
    m_brk = 0; m_extf = 0; m_skip = 0;
    exp_code = 8'h00; exp_make = 0; exp_ext = 0;
    reset = 1'b1;
    repeat (30) @(negedge clock);
    send_frame(8'h1C, 0, 0, 0);

    // Random traffic with occasional prefixes, protocol bytes, bad frames and glitches
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 11);
      case (pick)
        0: rb = 8'hE0;
        1, 2: rb = 8'hF0;
        3: rb = 8'hE1;
        4: rb = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hAA;
        default: rb = 8'($urandom);
      endcase
      pick = $urandom_range(0, 15);
      send_frame(rb, pick == 0, pick == 1, 1'b1);
    end

    check("total_strb", strb_total, exp_events);
    check("total_perr", perr_total, exp_perrs);
    check("strb_back_to_back", strb_b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
